// File: rtl/imm_decode_if.sv
// imm_decode_if: fetch-side and execute-side handshake bundle
// for the immediate decode stage.
interface imm_decode_if #(
   parameter int INSTR_WIDTH = 9,
   parameter int DATA_WIDTH  = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [INSTR_WIDTH-1:0] in_instr;
   logic                   out_valid;
   logic                   out_ready;
   logic [2:0]             out_opcode;
   logic [2:0]             out_rd;
   logic [DATA_WIDTH-1:0]  out_imm;
   logic [1:0]             out_imm_width;
   logic                   out_is_sign_ext;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_opcode, out_rd,
      input  out_imm, out_imm_width, out_is_sign_ext
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_opcode, out_rd,
      output out_imm, out_imm_width, out_is_sign_ext
   );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registers one decoded instruction per cycle
// for the immediate extender; PFX supplies upper immediate bits.
module imm_decode_stage #(
   parameter int INSTR_WIDTH = 9,
   parameter int DATA_WIDTH  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   imm_decode_if.slave bus,
   output logic        pfx_pending
);
   typedef enum logic {NORMAL, PREFIXED} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [4:0]            pfx_q;

   logic                  valid_q;
   logic [2:0]            opcode_q;
   logic [2:0]            rd_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic [1:0]            width_q;
   logic                  sign_q;

   logic [2:0]            op;
   logic                  is_r;
   logic                  is_addi;
   logic                  is_br;
   logic                  is_ldi;
   logic                  is_pfx;

   logic                  ready;
   logic                  accept;
   logic                  issue;
   logic                  xfer_out;

   logic [2:0]            rd_d;
   logic [DATA_WIDTH-1:0] imm_d;
   logic [1:0]            width_d;
   logic                  sign_d;

   assign op      = bus.in_instr[INSTR_WIDTH-1 -: 3];
   assign is_r    = !op[2];
   assign is_addi = (op == 3'b100);
   assign is_br   = (op == 3'b101);
   assign is_ldi  = (op == 3'b110);
   assign is_pfx  = (op == 3'b111);

   assign ready    = !flush && (!valid_q || bus.out_ready);
   assign accept   = bus.in_valid && ready;
   assign issue    = accept && !is_pfx;
   assign xfer_out = valid_q && bus.out_ready;

   assign bus.in_ready        = ready;
   assign bus.out_valid       = valid_q;
   assign bus.out_opcode      = opcode_q;
   assign bus.out_rd          = rd_q;
   assign bus.out_imm         = imm_q;
   assign bus.out_imm_width   = width_q;
   assign bus.out_is_sign_ext = sign_q;
   assign pfx_pending         = (state_q == PREFIXED);

   // Field split; a pending prefix widens ADDI/LDI to a full immediate.
   always_comb begin
      rd_d    = bus.in_instr[5:3];
      imm_d   = '0;
      width_d = 2'd0;
      sign_d  = 1'b0;
      unique case (1'b1)
         is_addi, is_ldi: begin
            if (state_q == PREFIXED) begin
               imm_d   = DATA_WIDTH'({pfx_q, bus.in_instr[2:0]});
               width_d = 2'd2;
            end else begin
               imm_d  = DATA_WIDTH'(bus.in_instr[2:0]);
               sign_d = is_addi;
            end
         end
         is_br: begin
            rd_d    = '0;
            imm_d   = DATA_WIDTH'(bus.in_instr[5:0]);
            width_d = 2'd1;
            sign_d  = 1'b1;
         end
         is_r: ;
         is_pfx: ;
         default: ;
      endcase
   end

   // Prefix FSM next state: any accepted non-PFX consumes the prefix.
   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = NORMAL;
      else if (accept)
         state_d = is_pfx ? PREFIXED : NORMAL;
   end

   // Prefix FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= NORMAL;
      else
         state_q <= state_d;
   end

   // Prefix bits captured on every accepted PFX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pfx_q <= '0;
      else if (accept && is_pfx)
         pfx_q <= bus.in_instr[4:0];
   end

   // Output register: load on issue, drop on transfer or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         opcode_q <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         width_q  <= '0;
         sign_q   <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (issue) begin
         valid_q  <= 1'b1;
         opcode_q <= op;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         width_q  <= width_d;
         sign_q   <= sign_d;
      end else if (xfer_out) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-side pipeline stage directly upstream of the immediate extender.
- Accepts 9-bit instructions from fetch over a valid/ready handshake and registers them.
- Splits each instruction into opcode, rd, a right-aligned raw immediate, an immediate-width code and a sign-extend select; these feed the extender(s) and the execute stage.
- Handles a PFX prefix instruction that supplies the upper 5 bits of a full 8-bit immediate for the next ADDI/LDI.

Parameters:
INSTR_WIDTH, 9, instruction width; encoding below is fixed for 9.
DATA_WIDTH, 8, datapath width; width of out_imm.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage accepts in_instr this cycle.
in_instr  input  INSTR_WIDTH  instruction word.
flush  input  1  synchronous pipeline flush (branch redirect).
out_valid  output  1  registered decode result valid.
out_ready  input  1  downstream accepts result.
out_opcode  output  3  instr[8:6].
out_rd  output  3  destination register field.
out_imm  output  DATA_WIDTH  raw immediate, right-aligned, upper bits zero.
out_imm_width  output  2  0 = 3-bit, 1 = 6-bit, 2 = full 8-bit, 3 = unused.
out_is_sign_ext  output  1  extender select: 1 = sign-extend, 0 = zero-extend.
pfx_pending  output  1  prefix latched and not yet consumed.

Behaviour:
- Encoding: opcode = instr[8:6].
  - 000–011 R-type: rd = [5:3], imm 0, width 0, sign 0.
  - 100 ADDI: rd = [5:3], imm3 = [2:0], width 0, sign 1.
  - 101 BR: rd 0, off6 = [5:0], width 1, sign 1.
  - 110 LDI: rd = [5:3], imm3 = [2:0], width 0, sign 0.
  - 111 PFX: [4:0] = prefix bits, [5] ignored.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
  - Latency 1 cycle: a non-PFX instruction accepted in cycle N appears on the outputs in cycle N+1.
- While out_valid && !out_ready, all out_* are held stable.
- Accepting a non-PFX instruction sets out_valid and loads all output fields.
- out_valid clears on an out transfer with no new issuing acceptance in the same cycle.
- Simultaneous out transfer and in acceptance: the new instruction replaces the old one, out_valid stays 1 (full throughput).
- Prefix FSM, states NORMAL and PREFIXED; pfx_pending = (state == PREFIXED):
  - NORMAL, accept PFX: pfx_reg <= instr[4:0], go PREFIXED. Nothing issues; out_valid is unaffected except that a concurrent out transfer still clears it.
  - PREFIXED, accept PFX: overwrite pfx_reg, stay PREFIXED.
  - PREFIXED, accept ADDI or LDI: out_imm = {pfx_reg, imm3}, width 2, sign 0; go NORMAL.
  - PREFIXED, accept R-type or BR: prefix discarded, instruction issues exactly as in NORMAL; go NORMAL.
  - pfx_reg keeps its value while in NORMAL; it is only meaningful in PREFIXED.
- flush (synchronous, highest priority after reset):
  - Next edge: out_valid 0, state NORMAL.
  - in_ready is 0 during flush, so the concurrent in_instr is dropped.
  - out_* data fields need not change.
- Reset (async, active-low): out_valid 0, out_opcode/out_rd/out_imm/out_imm_width/out_is_sign_ext 0, pfx_reg 0, state NORMAL, pfx_pending 0.
  - in_ready reads 1 while rst_n = 1 with no flush.
  - Asserting rst_n low mid-handshake discards the held result immediately, without waiting for a clock edge.
- in_instr is sampled only on acceptance; its value when in_valid = 0 is don't-care.

Test Plan:
- ADDI 9'b100_010_101, out_ready = 1 → next cycle: out_valid 1, opcode 3'b100, rd 2, out_imm 8'h05, width 0, sign 1.
- PFX 9'b111_0_10110 then LDI 9'b110_001_011 →
  - pfx_pending 1 for the cycle between them.
  - Exactly one output: rd 1, out_imm 8'hB3, width 2, sign 0.
  - pfx_pending 0 after the LDI.
- BR 9'b101_111100 with out_ready = 0 for 3 cycles, ADDI waiting on the input →
  - out_imm 8'h3C, width 1, sign 1, held stable; in_ready 0; ADDI not accepted.
  - out_ready 1 → BR transfers and ADDI is accepted the same cycle.
- PFX 9'b111_0_11111 then BR 9'b101_000011 → out_imm 8'h03, width 1, sign 1 (prefix not applied); pfx_pending 0.
- out_valid 1, pfx_pending 1, flush with in_valid 1 (ADDI) → next cycle out_valid 0, pfx_pending 0, ADDI never issues.
- rst_n dropped between edges with out_valid 1 → out_valid and all out_* 0 immediately; after release, in_ready 1 and the first ADDI issues normally.
